uart_scan_ctrl: RTL and testbench

UART_SCAN_CTRL -- requirements
Module: uart_scan_ctrl

---
 rtl/uart_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_scan_ctrl.sv
// UART-to-scan bridge: serialises received bytes LSB first onto tck/tdi/tms and tracks tap address/data count.
// Optional SCAN_HOLD_BUF_EN adds a one-byte holding buffer for bytes arriving while a shift is in progress.
module uart_scan_ctrl #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_mode,
   output logic        tck,
   output logic        tdi,
   output logic        tms,
   output logic [15:0] addr,
   output logic [7:0]  data_count,
   output logic        busy,
   output logic        overrun
);

   // state    | meaning
   // IDLE     | no byte shifting, tdi=1 tms=0 tck=0
   // SHIFT_LO | tck low half-period, tdi/tms presented
   // SHIFT_HI | tck high half-period, tdi/tms held
   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI} state_t;

   localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

   state_t      state, state_nxt;
   logic [7:0]  div_cnt;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        mode_reg;
   logic        div_tc, last_bit;
   logic        start_rx, start_hold, rx_drop;
   logic [7:0]  start_data;
   logic        start_mode;
   logic        hold_valid;
   logic [7:0]  hold_data;
   logic        hold_mode;
`ifdef SCAN_HOLD_BUF_EN
   logic        hold_load;
`endif

   assign div_tc     = (div_cnt == 8'd0);
   assign last_bit   = (bit_cnt == 3'd7);
   assign start_data = start_hold ? hold_data : rx_data;
   assign start_mode = start_hold ? hold_mode : rx_mode;

   always_comb begin
      state_nxt  = state;
      start_rx   = 1'b0;
      start_hold = 1'b0;
      rx_drop    = 1'b0;
`ifdef SCAN_HOLD_BUF_EN
      hold_load  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (hold_valid) begin
               start_hold = 1'b1;
               state_nxt  = SHIFT_LO;
            end else if (rx_valid) begin
               start_rx  = 1'b1;
               state_nxt = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (div_tc) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (div_tc) begin
               if (!last_bit) begin
                  state_nxt = SHIFT_LO;
               end else if (hold_valid) begin
                  start_hold = 1'b1;
                  state_nxt  = SHIFT_LO;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // a byte not started directly goes to the buffer if it is (or is becoming) free
      if (rx_valid && !start_rx) begin
`ifdef SCAN_HOLD_BUF_EN
         if (!hold_valid || start_hold) hold_load = 1'b1;
         else                           rx_drop   = 1'b1;
`else
         rx_drop = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         tck   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         tck   <= (state_nxt == SHIFT_HI);
         busy  <= (state_nxt != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         mode_reg   <= 1'b0;
         addr       <= '0;
         data_count <= '0;
         overrun    <= 1'b0;
      end else begin
         if (rx_drop) overrun <= 1'b1;
         if (start_rx || start_hold) begin
            shreg    <= start_data;
            mode_reg <= start_mode;
            bit_cnt  <= '0;
            div_cnt  <= DIV_LD;
            if (!start_mode) begin
               addr       <= {addr[7:0], start_data};
               data_count <= '0;
            end else begin
               data_count <= data_count + 8'd1;
            end
         end else if (state != IDLE) begin
            if (div_tc) begin
               div_cnt <= DIV_LD;
               if (state == SHIFT_HI) begin
                  shreg   <= {1'b1, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end else begin
               div_cnt <= div_cnt - 8'd1;
            end
         end
      end
   end

`ifdef SCAN_HOLD_BUF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         hold_mode  <= 1'b0;
      end else if (hold_load) begin
         hold_valid <= 1'b1;
         hold_data  <= rx_data;
         hold_mode  <= rx_mode;
      end else if (start_hold) begin
         hold_valid <= 1'b0;
      end
   end
`else
   assign hold_valid = 1'b0;
   assign hold_data  = 8'h00;
   assign hold_mode  = 1'b0;
`endif

   assign tdi = busy ? shreg[0] : 1'b1;
   assign tms = busy ? mode_reg : 1'b0;

endmodule

// File: tb/tb_uart_scan_ctrl.sv
// Self-checking bench for uart_scan_ctrl (CLK_DIV=4): vector table, buffer/overrun and reset corners, random bytes vs. model.
module tb_uart_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_mode = 1'b0;
   logic        tck, tdi, tms, busy, overrun;
   logic [15:0] addr;
   logic [7:0]  data_count;

   int n_cmp = 0;
   int n_err = 0;
   int run = 0;
   int last_run = 0;
   logic tdi_q[$];
   logic tms_q[$];

   uart_scan_ctrl #(.CLK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_mode(rx_mode),
      .tck(tck), .tdi(tdi), .tms(tms), .addr(addr), .data_count(data_count),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge tck) begin
      tdi_q.push_back(tdi);
      tms_q.push_back(tms);
   end

   always @(negedge clk) begin
      if (busy) run = run + 1;
      else if (run != 0) begin
         last_run = run;
         run = 0;
      end
   end

   typedef struct {
      logic [7:0]  data;
      logic        mode;
      logic [15:0] exp_addr;
      logic [7:0]  exp_cnt;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic m);
      @(negedge clk);
      rx_data  = b;
      rx_mode  = m;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", busy, 0);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [7:0] q_byte(input int off);
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b[i] = tdi_q[off + i];
      return b;
   endfunction

   function automatic logic tms_all(input int n, input logic m);
      logic ok = 1'b1;
      for (int i = 0; i < n; i++) if (tms_q[i] !== m) ok = 1'b0;
      return ok;
   endfunction

   task automatic check_byte(input string name, input logic [7:0] b, input logic m);
      check({name, "_nbits"}, tdi_q.size(), 8);
      if (tdi_q.size() >= 8) begin
         check({name, "_tdi"}, q_byte(0), b);
         check({name, "_tms"}, tms_all(8, m), 1);
      end
   endtask

   initial begin
      logic [15:0] addr_m;
      logic [7:0]  cnt_m;
      logic [7:0]  b;
      logic        m;

      vecs[0] = '{8'hA5, 1'b0, 16'h00A5, 8'd0};
      vecs[1] = '{8'h00, 1'b0, 16'hA500, 8'd0};
      vecs[2] = '{8'h02, 1'b0, 16'h0002, 8'd0};
      vecs[3] = '{8'h7F, 1'b1, 16'h0002, 8'd1};
      vecs[4] = '{8'h08, 1'b1, 16'h0002, 8'd2};
      vecs[5] = '{8'h5A, 1'b0, 16'h025A, 8'd0};

      repeat (3) @(negedge clk);
      check("rst_tck", tck, 0);
      check("rst_tdi", tdi, 1);
      check("rst_tms", tms, 0);
      check("rst_addr", addr, 16'h0000);
      check("rst_cnt", data_count, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", overrun, 0);
      rst_n = 1'b1;

      // table: address and data bytes, spaced 200 cycles
      for (int v = 0; v < 6; v++) begin
         tdi_q.delete();
         tms_q.delete();
         send(vecs[v].data, vecs[v].mode);
         if (v == 0) check("busy_next_cycle", busy, 1);
         repeat (198) @(negedge clk);
         check("tbl_addr", addr, vecs[v].exp_addr);
         check("tbl_cnt", data_count, vecs[v].exp_cnt);
         check("tbl_burst", last_run, 64);
         check("tbl_idle_tdi", tdi, 1);
         check("tbl_idle_tms", tms, 0);
         check_byte("tbl", vecs[v].data, vecs[v].mode);
      end

      // byte arriving 10 cycles into a shift
      tdi_q.delete();
      tms_q.delete();
      send(8'h3C, 1'b1);
      repeat (9) @(negedge clk);
      send(8'hC3, 1'b1);
      repeat (200) @(negedge clk);
`ifdef SCAN_HOLD_BUF_EN
      check("ovr_burst", last_run, 128);
      check("ovr_flag", overrun, 0);
      check("ovr_cnt", data_count, 2);
      check("ovr_nbits", tdi_q.size(), 16);
      if (tdi_q.size() >= 16) check("ovr_tdi2", q_byte(8), 8'hC3);
`else
      check("ovr_burst", last_run, 64);
      check("ovr_flag", overrun, 1);
      check("ovr_cnt", data_count, 1);
      check("ovr_nbits", tdi_q.size(), 8);
`endif
      if (tdi_q.size() >= 8) check("ovr_tdi1", q_byte(0), 8'h3C);
      check("ovr_addr", addr, 16'h025A);

      // asynchronous reset during bit 3
      send(8'h96, 1'b0);
      repeat (26) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_tck", tck, 0);
      check("arst_busy", busy, 0);
      check("arst_addr", addr, 16'h0000);
      check("arst_cnt", data_count, 0);
      check("arst_tdi", tdi, 1);
      check("arst_ovr", overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tdi_q.delete();
      tms_q.delete();
      send(8'h81, 1'b1);
      wait_idle();
      check_byte("post_rst", 8'h81, 1'b1);
      check("post_rst_burst", last_run, 64);
      check("post_rst_cnt", data_count, 1);
      check("post_rst_addr", addr, 16'h0000);

      // random bytes vs. model
      addr_m = 16'h0000;
      cnt_m  = 8'd1;
      for (int k = 0; k < 40; k++) begin
         b = 8'($urandom);
         m = 1'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         tdi_q.delete();
         tms_q.delete();
         send(b, m);
         if (m) cnt_m = cnt_m + 8'd1;
         else begin
            addr_m = {addr_m[7:0], b};
            cnt_m  = 8'd0;
         end
         wait_idle();
         check("rnd_addr", addr, addr_m);
         check("rnd_cnt", data_count, cnt_m);
         check("rnd_burst", last_run, 64);
         check_byte("rnd", b, m);
      end

      // data_count wrap
      send(8'h11, 1'b0);
      addr_m = {addr_m[7:0], 8'h11};
      wait_idle();
      check("wrap_start", data_count, 0);
      for (int k = 0; k < 256; k++) begin
         send(8'($urandom), 1'b1);
         wait_idle();
         if (k == 254) check("wrap_255", data_count, 255);
      end
      check("wrap_0", data_count, 0);
      check("wrap_addr", addr, addr_m);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
